alu_mul_sequencer: RTL and testbench

- Iterative shift-add multiplier that time-shares the existing 32-bit EXE-stage ALU with the pipeline.
- When a multiply is started, it takes over the ALU's val1/val2/EXE_CMD inputs and drives alternating ADD and SLA operations until the low WIDTH bits of the product are formed.
- While idle, it passes the EXE stage's operands straight through to the ALU. It asserts busy, which the hazard unit uses as a stall.

---
 rtl/alu_mul_sequencer_pkg.sv | 19 +
 rtl/alu_mul_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Purpose: shared ALU command codes and sequencer state encoding for alu_mul_sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_mul_sequencer_pkg;

    // ALU command codes, matching the EXE_CMD encoding the EXE-stage ALU decodes.
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SLA = 4'b1000;

    // Sequencer state encoding (2 bits).
    typedef enum logic [1:0] {
        MULSEQ_IDLE  = 2'd0,
        MULSEQ_ADD   = 2'd1,
        MULSEQ_SHIFT = 2'd2,
        MULSEQ_DONE  = 2'd3
    } mulseq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Purpose: shift-add multiplier that borrows the EXE-stage ALU, alternating ADD and SLA ops.
// Latency: 2*WIDTH+1 cycles from accepted start to done (data-dependent with MUL_EARLY_TERM_EN).
// Backpressure: start is ignored while busy; busy stalls the pipeline until the done cycle ends.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-low reset
//   start/op_a/op_b - multiply request and operands, accepted only when idle
//   busy/done       - stall indication / one-cycle result-valid pulse
//   result          - low WIDTH bits of op_a*op_b, held until the next completion
//   exe_val1/2/cmd  - pipeline ALU inputs, passed to alu_* while idle or done
//   alu_val1/2/cmd  - to the shared ALU; alu_out is its result
//
// Build option: define MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier
// bits are all zero (a zero multiplier completes in one cycle).
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CMD_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    input  logic [WIDTH-1:0]    exe_val1,
    input  logic [WIDTH-1:0]    exe_val2,
    input  logic [CMD_SIZE-1:0] exe_cmd,
    output logic [WIDTH-1:0]    alu_val1,
    output logic [WIDTH-1:0]    alu_val2,
    output logic [CMD_SIZE-1:0] alu_cmd,
    input  logic [WIDTH-1:0]    alu_out
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    mulseq_state_t    state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             last_iter;

    // Last SHIFT of the run: all multiplier bits consumed (or, with early
    // termination, nothing but zeros left above the bit just used).
`ifdef MUL_EARLY_TERM_EN
    assign last_iter = (cnt == CNT_LAST) || ((mplier >> 1) == '0);
`else
    assign last_iter = (cnt == CNT_LAST);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MULSEQ_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                MULSEQ_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc    <= '0;
                        mcand  <= op_a;
                        mplier <= op_b;
                        cnt    <= '0;
                        busy   <= 1'b1;
`ifdef MUL_EARLY_TERM_EN
                        if (op_b == '0) begin
                            state  <= MULSEQ_DONE;
                            result <= '0;
                            done   <= 1'b1;
                        end else begin
                            state  <= MULSEQ_ADD;
                        end
`else
                        state  <= MULSEQ_ADD;
`endif
                    end
                end
                MULSEQ_ADD: begin
                    // ALU is computing acc + mcand; keep it only for a set multiplier bit.
                    if (mplier[0]) begin
                        acc <= alu_out;
                    end
                    state <= MULSEQ_SHIFT;
                end
                MULSEQ_SHIFT: begin
                    // ALU is computing mcand << 1; the multiplier shifts locally.
                    mcand  <= alu_out;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        state  <= MULSEQ_DONE;
                        result <= acc;
                        done   <= 1'b1;
                    end else begin
                        state  <= MULSEQ_ADD;
                    end
                end
                MULSEQ_DONE: begin
                    state <= MULSEQ_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= MULSEQ_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // ALU input mux: decoded from the state register so reset returns the
    // ALU to the pipeline immediately.
    always_comb begin
        alu_val1 = exe_val1;
        alu_val2 = exe_val2;
        alu_cmd  = exe_cmd;
        case (state)
            MULSEQ_ADD: begin
                alu_val1 = acc;
                alu_val2 = mcand;
                alu_cmd  = CMD_SIZE'(EXE_ADD);
            end
            MULSEQ_SHIFT: begin
                alu_val1 = mcand;
                alu_val2 = WIDTH'(1);
                alu_cmd  = CMD_SIZE'(EXE_SLA);
            end
            default: begin
                alu_val1 = exe_val1;
                alu_val2 = exe_val2;
                alu_cmd  = exe_cmd;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Purpose: scoreboard bench for alu_mul_sequencer with a behavioural ALU model on alu_*.
// Latency: expected done cycle derived from operands (fixed or early-terminated build).
// Backpressure: exercises start-while-busy and reset mid-multiply.
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    localparam int W = 32;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   op_a, op_b;
    logic           busy, done;
    logic [W-1:0]   result;
    logic [W-1:0]   exe_val1, exe_val2;
    logic [C-1:0]   exe_cmd;
    logic [W-1:0]   alu_val1, alu_val2, alu_out;
    logic [C-1:0]   alu_cmd;

    always #5 clk = ~clk;

    // Behavioural EXE-stage ALU.
    always_comb begin
        alu_out = '0;
        case (alu_cmd)
            EXE_ADD: alu_out = alu_val1 + alu_val2;
            EXE_SUB: alu_out = alu_val1 - alu_val2;
            EXE_SLA: alu_out = alu_val1 << alu_val2;
            default: alu_out = '0;
        endcase
    end

    alu_mul_sequencer #(.WIDTH(W), .CMD_SIZE(C)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result),
        .exe_val1(exe_val1), .exe_val2(exe_val2), .exe_cmd(exe_cmd),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cmd(alu_cmd),
        .alu_out(alu_out)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           at;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done required=no_done at cyc=%0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_result", result, e.res);
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    // Number of ADD/SHIFT pairs the sequencer should run for multiplier b.
    function automatic int n_pairs(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        int p = 0;
        for (int i = 0; i < W; i++) if (b[i]) p = i + 1;
        return p;
`else
        return W;
`endif
    endfunction

    // Called on a negedge; returns on the negedge of cycle n+1.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
        int n, s, bad_busy, bad_done, adds, slas;
        logic [W-1:0] prod;
        n = 2 * n_pairs(b) + 1;
        bad_busy = 0; bad_done = 0; adds = 0; slas = 0;
        prod  = a * b;
        start = 1'b1; op_a = a; op_b = b;
        s = cyc + 1;
        sb.push_back('{prod, s + n - 1});
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            start = (k == inj);
            if (k == inj) begin op_a = 3; op_b = 3; end
            if (busy !== (k <= n)) bad_busy++;
            if (done !== (k == n)) bad_done++;
            if (busy && alu_cmd == EXE_ADD) adds++;
            if (busy && alu_cmd == EXE_SLA) slas++;
            if (k == 1 && n > 1) begin
                chk("add_cmd", alu_cmd, EXE_ADD);
                chk("add_val1", alu_val1, 0);
                chk("add_val2", alu_val2, a);
            end
            if (k == 2 && n > 1) begin
                chk("sla_cmd", alu_cmd, EXE_SLA);
                chk("sla_val1", alu_val1, a);
                chk("sla_val2", alu_val2, 1);
            end
        end
        start = 1'b0;
        chk("busy_profile_errs", bad_busy, 0);
        chk("done_pulse_errs", bad_done, 0);
        chk("add_count", adds, (n - 1) / 2);
        chk("sla_count", slas, (n - 1) / 2);
        chk("result_held", result, prod);
        chk("passthru_after", alu_cmd, exe_cmd);
    endtask

    initial begin
        int idle_busy;
        rst = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
        exe_val1 = 7; exe_val2 = 5; exe_cmd = EXE_SUB;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_alu_cmd", alu_cmd, EXE_SUB);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Idle pass-through.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pt_val1", alu_val1, 7);
            chk("pt_val2", alu_val2, 5);
            chk("pt_cmd", alu_cmd, EXE_SUB);
            chk("pt_busy", busy, 0);
        end

        run_mul(32'd6, 32'd7, 0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_mul(32'h1234_5678, 32'h10, 0);
        run_mul(32'd3, 32'h8000_0000, 0);
        run_mul(32'd9, 32'd5, 0);
        run_mul(32'hDEAD_BEEF, 32'd0, 0);

        // Start pulse while busy is dropped: one done, result 42, no rerun.
        run_mul(32'd6, 32'd7, (2 * n_pairs(32'd7) + 1 > 12) ? 10 : 2 * n_pairs(32'd7) - 1);
        idle_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) idle_busy++;
        end
        chk("no_rerun_busy", idle_busy, 0);

        // Reset mid-multiply abandons the run without a done pulse.
        start = 1'b1; op_a = 32'd6; op_b = 32'h8000_0001;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_val1", alu_val1, 7);
        chk("arst_cmd", alu_cmd, EXE_SUB);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_mul(32'd12, 32'd11, 0);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
